fp16_round_pack: RTL and testbench
==================================

Name: fp16_round_pack

Overview:
- Pipelined normalize/round/pack stage directly downstream of the fp16 magnitude multiplier.
- Consumes the raw 22-bit significand product, the unadjusted biased exponent, the sign and special-class info.
- Produces a packed IEEE-754 binary16 result with exception flags.
- 2-stage valid/ready pipeline, throughput 1 result/cycle, round-to-nearest-even, subnormal results flushed to zero.

Parameters:
- BIAS, 15, exponent bias; IN_EXP is eA+eB-BIAS.
- QNAN, 16'h7E00, canonical quiet NaN emitted for NaN class.

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  input beat valid
- IN_READY  output  1  stage can accept a beat this cycle
- IN_SIGN  input  1  result sign (SIGN_A^SIGN_B)
- IN_EXP  input  7  signed two's-complement biased exponent before normalization
- IN_MANT  input  22  unsigned product of two 11-bit significands (value in [1,4) x 2^20)
- IN_CLASS  input  2  00 normal, 01 zero, 10 infinity, 11 NaN
- IN_NV  input  1  invalid-operation flag from upstream (e.g. inf*0), passed to FLAGS[4]
- OUT_VALID  output  1  Q/FLAGS valid
- OUT_READY  input  1  downstream accepts
- Q  output  16  packed binary16 result
- FLAGS  output  5  [4]=NV, [3]=DZ (always 0), [2]=UF, [1]=OF, [0]=NX

Behaviour:
- Reset (async, any time incl. mid-stream): both stage valids=0, OUT_VALID=0, Q=16'h0000, FLAGS=5'b0, all in-flight beats discarded. IN_READY=1 once RST deasserts.
- Handshake: transfer on VALID&READY at each side. en2 = !OUT_VALID | OUT_READY; en1 = !s1_valid | en2; IN_READY = en1 (combinational from OUT_READY).
- Latency 2 cycles from input accept to OUT_VALID when unstalled; no bubbles under continuous flow. Stalled outputs hold Q/FLAGS stable. Data registers load only when their stage enables.
- Stage 1 (normalize + round decision):
  - If IN_MANT[21]: frac=IN_MANT[20:11], G=IN_MANT[10], S=|IN_MANT[9:0], E=IN_EXP+1.
  - Else: frac=IN_MANT[19:10], G=IN_MANT[9], S=|IN_MANT[8:0], E=IN_EXP.
  - E is 8-bit signed (no wrap).
  - inc = G & (S | frac[0]) (RNE).
  - inexact = G|S.
  - Register sign, E, frac, inc, inexact, class, NV.
- Stage 2 (apply + pack):
  - {c,f} = {1'b0,frac}+inc; if c, E=E+1, f=0.
  - Normal class:
    - E>=31: Q={sign,5'h1F,10'h0}, OF=1, NX=1.
    - E<=0: Q={sign,15'h0}, UF=1, NX=1.
    - Otherwise: Q={sign,E[4:0],f}, NX=inexact, UF=OF=0.
  - Zero class: Q={sign,15'h0}, flags 0 except NV.
  - Inf class: Q={sign,5'h1F,10'h0}.
  - NaN class: Q=QNAN (sign ignored), no OF/UF/NX.
  - NV=IN_NV in all classes; DZ always 0.
- Underflow/overflow decided after rounding (a carry at E=30 overflows; a carry from E=0 does not rescue).
- IN_MANT with bit21=bit20=0 is illegal for normal class; output is don't-care but must not hang the pipeline.

Test Plan:
- 1.0*1.0: IN_EXP=15, IN_MANT=22'h100000, class 00 -> Q=16'h3C00, FLAGS=0, OUT_VALID exactly 2 cycles after accept.
- 1.5*1.5: IN_EXP=15, IN_MANT=22'h240000 -> Q=16'h4080, FLAGS=0. Ties: IN_MANT=22'h100200 -> Q=16'h3C00, NX. IN_MANT=22'h100600 -> Q=16'h3C02, NX.
- Round carry: IN_EXP=15, IN_MANT=22'h1FFE00 -> Q=16'h4000, FLAGS=5'b00001. Overflow: IN_EXP=31, IN_MANT=22'h100000 -> Q=16'h7C00, FLAGS=5'b00011.
- Underflow: IN_SIGN=1, IN_EXP=0, IN_MANT=22'h100000 -> Q=16'h8000, FLAGS=5'b00101. Class 11 with IN_NV=1 -> Q=16'h7E00, FLAGS=5'b10000.
- Backpressure: stream 5 beats, hold OUT_READY=0 for 4 cycles -> IN_READY drops after 2 beats buffered, Q stable while stalled, all 5 results emerge in order, none lost or duplicated.
- Reset mid-operation: assert RST with 2 beats in flight -> OUT_VALID=0, Q=0, FLAGS=0 immediately (async); after release the next beat returns correctly with 2-cycle latency.

Source files
------------

// File: rtl/fp16_round_pack.sv
// Normalize, round-to-nearest-even and pack stage for the fp16 multiplier.
// Two-stage valid/ready pipeline; subnormal results are flushed to signed zero.
module fp16_round_pack #(
    parameter int unsigned BIAS = 15,
    parameter logic [15:0] QNAN = 16'h7E00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_SIGN,
    input  logic [6:0]  IN_EXP,
    input  logic [21:0] IN_MANT,
    input  logic [1:0]  IN_CLASS,
    input  logic        IN_NV,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] Q,
    output logic [4:0]  FLAGS
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 10;
    localparam logic signed [EXP_W-1:0] EMAX = EXP_W'(2 * BIAS + 1);

    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ZERO   = 2'b01;
    localparam logic [1:0] CLS_INF    = 2'b10;
    localparam logic [1:0] CLS_NAN    = 2'b11;

    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic signed [EXP_W-1:0] r_s1_exp;
    logic [FRAC_W-1:0]       r_s1_frac;
    logic                    r_s1_inc;
    logic                    r_s1_nx;
    logic [1:0]              r_s1_class;
    logic                    r_s1_nv;

    logic                    r_out_valid;
    logic [15:0]             r_q;
    logic [4:0]              r_flags;

    logic                    w_en1;
    logic                    w_en2;
    logic [FRAC_W-1:0]       w_frac1;
    logic                    w_g1;
    logic                    w_st1;
    logic signed [EXP_W-1:0] w_exp1;
    logic                    w_inc1;
    logic                    w_nx1;
    logic [FRAC_W:0]         w_sum;
    logic signed [EXP_W-1:0] w_exp2;
    logic [15:0]             w_q;
    logic [4:0]              w_flags;

    assign w_en2     = !r_out_valid || OUT_READY;
    assign w_en1     = !r_s1_valid || w_en2;
    assign IN_READY  = w_en1;
    assign OUT_VALID = r_out_valid;
    assign Q         = r_q;
    assign FLAGS     = r_flags;

    // Stage 1: pick the leading-one window and derive guard/sticky
    always_comb begin
        w_frac1 = IN_MANT[19:10];
        w_g1    = IN_MANT[9];
        w_st1   = |IN_MANT[8:0];
        w_exp1  = {IN_EXP[6], IN_EXP};
        if (IN_MANT[21]) begin
            w_frac1 = IN_MANT[20:11];
            w_g1    = IN_MANT[10];
            w_st1   = |IN_MANT[9:0];
            w_exp1  = {IN_EXP[6], IN_EXP} + 8'sd1;
        end
    end

    assign w_inc1 = w_g1 && (w_st1 || w_frac1[0]);
    assign w_nx1  = w_g1 || w_st1;

    // Stage 2: apply the rounding increment; a carry bumps the exponent
    assign w_sum  = {1'b0, r_s1_frac} + {{FRAC_W{1'b0}}, r_s1_inc};
    assign w_exp2 = r_s1_exp + $signed({{(EXP_W-1){1'b0}}, w_sum[FRAC_W]});

    always_comb begin
        w_q        = {r_s1_sign, 15'h0000};
        w_flags    = 5'b00000;
        w_flags[4] = r_s1_nv;
        case (r_s1_class)
            CLS_NORMAL: begin
                if (w_exp2 >= EMAX) begin
                    w_q        = {r_s1_sign, 5'h1F, 10'h000};
                    w_flags[1] = 1'b1;
                    w_flags[0] = 1'b1;
                end else if (r_s1_exp <= 8'sd0) begin
                    // rounding carry out of a tiny value does not lift it to normal
                    w_flags[2] = 1'b1;
                    w_flags[0] = 1'b1;
                end else begin
                    w_q        = {r_s1_sign, w_exp2[4:0], w_sum[FRAC_W-1:0]};
                    w_flags[0] = r_s1_nx;
                end
            end
            CLS_ZERO: w_q = {r_s1_sign, 15'h0000};
            CLS_INF:  w_q = {r_s1_sign, 5'h1F, 10'h000};
            CLS_NAN:  w_q = QNAN;
            default:  w_q = {r_s1_sign, 15'h0000};
        endcase
    end

    // Stage 1 registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_inc   <= 1'b0;
            r_s1_nx    <= 1'b0;
            r_s1_class <= CLS_ZERO;
            r_s1_nv    <= 1'b0;
        end else if (w_en1) begin
            r_s1_valid <= IN_VALID;
            if (IN_VALID) begin
                r_s1_sign  <= IN_SIGN;
                r_s1_exp   <= w_exp1;
                r_s1_frac  <= w_frac1;
                r_s1_inc   <= w_inc1;
                r_s1_nx    <= w_nx1;
                r_s1_class <= IN_CLASS;
                r_s1_nv    <= IN_NV;
            end
        end
    end

    // Output registers hold while stalled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_q         <= 16'h0000;
            r_flags     <= 5'b00000;
        end else if (w_en2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_q     <= w_q;
                r_flags <= w_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp16_round_pack.sv
// Directed bench for fp16_round_pack: rounding, specials, backpressure and async reset.
module tb_fp16_round_pack;

    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_SIGN;
    logic [6:0]  IN_EXP;
    logic [21:0] IN_MANT;
    logic [1:0]  IN_CLASS;
    logic        IN_NV;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] Q;
    logic [4:0]  FLAGS;

    int n_tests = 0;
    int n_fail  = 0;

    fp16_round_pack dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_SIGN   (IN_SIGN),
        .IN_EXP    (IN_EXP),
        .IN_MANT   (IN_MANT),
        .IN_CLASS  (IN_CLASS),
        .IN_NV     (IN_NV),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Q         (Q),
        .FLAGS     (FLAGS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [6:0] e, input logic [21:0] m,
                         input logic [1:0] c, input logic nv);
        IN_SIGN  = s;
        IN_EXP   = e;
        IN_MANT  = m;
        IN_CLASS = c;
        IN_NV    = nv;
    endtask

    // One beat through an idle pipeline: checks 2-cycle latency and the result
    task automatic run1(input string tag, input logic s, input logic [6:0] e,
                        input logic [21:0] m, input logic [1:0] c, input logic nv,
                        input logic [15:0] eq, input logic [4:0] ef);
        @(negedge CLK);
        OUT_READY = 1'b1;
        drive(s, e, m, c, nv);
        IN_VALID = 1'b1;
        #1;
        chk({tag, " in_ready"}, 16'(IN_READY), 16'd1);
        @(posedge CLK);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk({tag, " valid_c1"}, 16'(OUT_VALID), 16'd0);
        @(negedge CLK);
        chk({tag, " valid_c2"}, 16'(OUT_VALID), 16'd1);
        chk({tag, " q"}, Q, eq);
        chk({tag, " flags"}, 16'(FLAGS), 16'(ef));
    endtask

    logic [6:0]  b_exp  [5] = '{7'd15, 7'd15, 7'd15, 7'd15, 7'd16};
    logic [21:0] b_mant [5] = '{22'h100000, 22'h240000, 22'h100600, 22'h1FFE00, 22'h100000};
    logic        b_sign [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] b_q    [5] = '{16'h3C00, 16'h4080, 16'h3C02, 16'h4000, 16'hC000};
    logic [4:0]  b_fl   [5] = '{5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00000};

    initial begin
        int tx;
        int rx;
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        drive(1'b0, 7'd0, 22'd0, 2'b00, 1'b0);
        #12;
        chk("reset out_valid", 16'(OUT_VALID), 16'd0);
        chk("reset q", Q, 16'h0000);
        chk("reset flags", 16'(FLAGS), 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset in_ready", 16'(IN_READY), 16'd1);

        run1("one_x_one",   1'b0, 7'd15, 22'h100000, 2'b00, 1'b0, 16'h3C00, 5'b00000);
        run1("1p5_x_1p5",   1'b0, 7'd15, 22'h240000, 2'b00, 1'b0, 16'h4080, 5'b00000);
        run1("tie_even",    1'b0, 7'd15, 22'h100200, 2'b00, 1'b0, 16'h3C00, 5'b00001);
        run1("tie_odd",     1'b0, 7'd15, 22'h100600, 2'b00, 1'b0, 16'h3C02, 5'b00001);
        run1("round_carry", 1'b0, 7'd15, 22'h1FFE00, 2'b00, 1'b0, 16'h4000, 5'b00001);
        run1("overflow",    1'b0, 7'd31, 22'h100000, 2'b00, 1'b0, 16'h7C00, 5'b00011);
        run1("carry_e30",   1'b0, 7'd30, 22'h1FFE00, 2'b00, 1'b0, 16'h7C00, 5'b00011);
        run1("max_normal",  1'b0, 7'd30, 22'h1FF800, 2'b00, 1'b0, 16'h7BFE, 5'b00000);
        run1("underflow",   1'b1, 7'd0,  22'h100000, 2'b00, 1'b0, 16'h8000, 5'b00101);
        run1("min_normal",  1'b1, 7'd1,  22'h100000, 2'b00, 1'b0, 16'h8400, 5'b00000);
        run1("nan_nv",      1'b1, 7'd15, 22'h100000, 2'b11, 1'b1, 16'h7E00, 5'b10000);
        run1("zero_neg",    1'b1, 7'd40, 22'h3FFFFF, 2'b01, 1'b0, 16'h8000, 5'b00000);
        run1("inf_nv",      1'b0, 7'd15, 22'h100000, 2'b10, 1'b1, 16'h7C00, 5'b10000);

        // Backpressure: stall the output for the first 4 cycles while streaming 5 beats
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge CLK);
            OUT_READY = (cyc >= 4);
            IN_VALID  = (tx < 5);
            if (tx < 5) drive(b_sign[tx], b_exp[tx], b_mant[tx], 2'b00, 1'b0);
            #1;
            if (cyc == 2 || cyc == 3) begin
                chk($sformatf("bp stall in_ready c%0d", cyc), 16'(IN_READY), 16'd0);
                chk($sformatf("bp stall valid c%0d", cyc), 16'(OUT_VALID), 16'd1);
                chk($sformatf("bp stall q c%0d", cyc), Q, b_q[0]);
            end
            if (OUT_VALID && OUT_READY) begin
                if (rx < 5) begin
                    chk($sformatf("bp q%0d", rx), Q, b_q[rx]);
                    chk($sformatf("bp flags%0d", rx), 16'(FLAGS), 16'(b_fl[rx]));
                end
                rx++;
            end
            if (IN_VALID && IN_READY) tx++;
            if (rx >= 5 && tx >= 5) break;
        end
        chk("bp sent", 16'(tx), 16'd5);
        chk("bp received", 16'(rx), 16'd5);
        @(negedge CLK);
        IN_VALID = 1'b0;
        @(negedge CLK);
        chk("bp no duplicate", 16'(OUT_VALID), 16'd0);

        // Async reset with two beats in flight
        @(negedge CLK);
        OUT_READY = 1'b1;
        drive(1'b0, 7'd15, 22'h100000, 2'b00, 1'b0);
        IN_VALID = 1'b1;
        @(negedge CLK);
        drive(1'b0, 7'd15, 22'h240000, 2'b00, 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("rst inflight valid", 16'(OUT_VALID), 16'd1);
        #1;
        RST = 1'b1;
        #1;
        chk("rst async valid", 16'(OUT_VALID), 16'd0);
        chk("rst async q", Q, 16'h0000);
        chk("rst async flags", 16'(FLAGS), 16'd0);
        @(negedge CLK);
        RST = 1'b0;
        run1("post_reset", 1'b0, 7'd15, 22'h100600, 2'b00, 1'b0, 16'h3C02, 5'b00001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
